branch_resolve_unit: RTL and testbench

- Back end of the branch-prediction loop. Fetch pushes each control-flow prediction (pc, taken, target) into an in-order in-flight queue.
- When EX/MEM resolves the oldest control-flow instruction, the unit compares the actual outcome with the queued prediction. On a mismatch it issues a registered redirect plus a multi-cycle flush.
- Every resolution produces a one-cycle training update for the gshare predictor.

---
 rtl/branch_resolve_unit.sv | 150 +++++++++++++++
 tb/tb_branch_resolve_unit.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: in-order prediction queue, mispredict redirect/flush, gshare training strobe.
// Optional BRU_PERF_CNT_EN adds saturating resolution/mispredict counters.
module branch_resolve_unit #(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int XLEN         = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pred_valid,
    input  logic [XLEN-1:0] pred_pc,
    input  logic            pred_taken,
    input  logic [XLEN-1:0] pred_target,
    output logic            pred_ready,
    input  logic            res_valid,
    input  logic            res_taken,
    input  logic [XLEN-1:0] res_target,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic            upd_valid,
    output logic [XLEN-1:0] upd_pc,
    output logic            upd_taken,
    output logic            mispredict,
    output logic            underflow_err
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [31:0]     perf_resolved,
    output logic [31:0]     perf_mispredict
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    logic [XLEN-1:0] pc_mem     [DEPTH];
    logic [XLEN-1:0] target_mem [DEPTH];
    logic            taken_mem  [DEPTH];

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [0:0]    state;
    logic [CW-1:0] flush_cnt;

    logic            empty;
    logic            full;
    logic            is_idle;
    logic            resolve;
    logic            detect;
    logic            push;
    logic [XLEN-1:0] head_pc;
    logic [XLEN-1:0] head_target;
    logic            head_taken;

    // The extra pointer MSB separates full (wrap bits differ) from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign is_idle = (state == IDLE);

    assign head_pc     = pc_mem[rd_ptr[AW-1:0]];
    assign head_target = target_mem[rd_ptr[AW-1:0]];
    assign head_taken  = taken_mem[rd_ptr[AW-1:0]];

    assign pred_ready = is_idle && (!full || res_valid);
    assign resolve    = is_idle && res_valid && !empty;
    assign detect     = resolve && ((res_taken != head_taken) ||
                                    (res_taken && head_taken && (res_target != head_target)));
    assign push       = pred_valid && pred_ready && !detect;
    assign flush      = (state == FLUSH);

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr[AW-1:0]]     <= pred_pc;
            taken_mem[wr_ptr[AW-1:0]]  <= pred_taken;
            target_mem[wr_ptr[AW-1:0]] <= pred_target;
        end
    end

    // A mispredict discards every younger entry, so both pointers restart at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (detect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)    wr_ptr <= wr_ptr + 1'b1;
            if (resolve) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            flush_cnt <= '0;
        end else if (state == IDLE) begin
            if (detect) begin
                state     <= FLUSH;
                flush_cnt <= CW'(FLUSH_CYCLES - 1);
            end
        end else begin
            if (flush_cnt == '0) state <= IDLE;
            else                 flush_cnt <= flush_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_valid      <= 1'b0;
            upd_pc         <= '0;
            upd_taken      <= 1'b0;
            mispredict     <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            underflow_err  <= 1'b0;
        end else begin
            upd_valid      <= resolve;
            mispredict     <= detect;
            redirect_valid <= detect;
            if (resolve) begin
                upd_pc    <= head_pc;
                upd_taken <= res_taken;
            end
            if (detect)
                redirect_pc <= res_taken ? res_target : head_pc + XLEN'(4);
            if (is_idle && res_valid && empty)
                underflow_err <= 1'b1;
        end
    end

`ifdef BRU_PERF_CNT_EN
    // Counters advance on the same edge that raises upd_valid and hold at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_resolved   <= '0;
            perf_mispredict <= '0;
        end else begin
            if (resolve && perf_resolved != 32'hFFFF_FFFF)
                perf_resolved <= perf_resolved + 1'b1;
            if (detect && perf_mispredict != 32'hFFFF_FFFF)
                perf_mispredict <= perf_mispredict + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (default parameters).
// Inputs change 1ns after each rising edge; outputs are sampled at that same point.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pred_valid = 1'b0;
    logic [31:0] pred_pc = '0;
    logic        pred_taken = 1'b0;
    logic [31:0] pred_target = '0;
    logic        pred_ready;
    logic        res_valid = 1'b0;
    logic        res_taken = 1'b0;
    logic [31:0] res_target = '0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        mispredict;
    logic        underflow_err;
`ifdef BRU_PERF_CNT_EN
    logic [31:0] perf_resolved;
    logic [31:0] perf_mispredict;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    branch_resolve_unit #(.DEPTH(4), .FLUSH_CYCLES(2), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .pred_target(pred_target), .pred_ready(pred_ready),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .mispredict(mispredict), .underflow_err(underflow_err)
`ifdef BRU_PERF_CNT_EN
        , .perf_resolved(perf_resolved), .perf_mispredict(perf_mispredict)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        pred_valid  = 1'b1;
        pred_pc     = pc;
        pred_taken  = tk;
        pred_target = tgt;
        tick();
        pred_valid  = 1'b0;
    endtask

    task automatic resolve(input logic tk, input logic [31:0] tgt);
        res_valid  = 1'b1;
        res_taken  = tk;
        res_target = tgt;
        tick();
        res_valid  = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #2;
        total_cnt++;
        if ({redirect_valid, flush, upd_valid, upd_taken, mispredict, underflow_err} !== 6'b0) begin
            $display("[TB] FAIL reset_flags: got %b expected 000000",
                     {redirect_valid, flush, upd_valid, upd_taken, mispredict, underflow_err});
        end else pass_cnt++;
        total_cnt++;
        if (upd_pc !== 32'h0 || redirect_pc !== 32'h0) begin
            $display("[TB] FAIL reset_pcs: got upd_pc=%h redirect_pc=%h expected 0", upd_pc, redirect_pc);
        end else pass_cnt++;
        total_cnt++;
        if (pred_ready !== 1'b1) begin
            $display("[TB] FAIL reset_pred_ready: got %b expected 1", pred_ready);
        end else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_correct;
        push(32'h100, 1'b1, 32'h140);
        resolve(1'b1, 32'h140);
        total_cnt++;
        if ({upd_valid, upd_taken, mispredict, redirect_valid, flush} !== 5'b11000) begin
            $display("[TB] FAIL correct_flags: got %b expected 11000",
                     {upd_valid, upd_taken, mispredict, redirect_valid, flush});
        end else pass_cnt++;
        total_cnt++;
        if (upd_pc !== 32'h100) begin
            $display("[TB] FAIL correct_upd_pc: got %h expected 00000100", upd_pc);
        end else pass_cnt++;
        tick();
        total_cnt++;
        if (upd_valid !== 1'b0) begin
            $display("[TB] FAIL correct_upd_pulse: got %b expected 0", upd_valid);
        end else pass_cnt++;
    endtask

    task automatic test_mispredict_taken;
        push(32'h200, 1'b0, 32'h0);
        push(32'h210, 1'b1, 32'h250);
        resolve(1'b1, 32'h260);
        total_cnt++;
        if ({upd_valid, mispredict, redirect_valid, flush} !== 4'b1111) begin
            $display("[TB] FAIL mispt_flags: got %b expected 1111",
                     {upd_valid, mispredict, redirect_valid, flush});
        end else pass_cnt++;
        total_cnt++;
        if (redirect_pc !== 32'h260 || upd_pc !== 32'h200) begin
            $display("[TB] FAIL mispt_pcs: got redirect_pc=%h upd_pc=%h expected 260/200", redirect_pc, upd_pc);
        end else pass_cnt++;
        tick();
        total_cnt++;
        if ({flush, redirect_valid, mispredict, pred_ready} !== 4'b1000) begin
            $display("[TB] FAIL mispt_flush2: got %b expected 1000", {flush, redirect_valid, mispredict, pred_ready});
        end else pass_cnt++;
        tick();
        total_cnt++;
        if ({flush, pred_ready} !== 2'b01) begin
            $display("[TB] FAIL mispt_flush_end: got %b expected 01", {flush, pred_ready});
        end else pass_cnt++;
        // The wrong-path 0x210 entry must be gone: the next resolution trains 0x220.
        push(32'h220, 1'b0, 32'h0);
        resolve(1'b0, 32'h0);
        total_cnt++;
        if (upd_valid !== 1'b1 || upd_pc !== 32'h220 || mispredict !== 1'b0) begin
            $display("[TB] FAIL mispt_queue_drained: got upd_valid=%b upd_pc=%h mispredict=%b expected 1/220/0",
                     upd_valid, upd_pc, mispredict);
        end else pass_cnt++;
    endtask

    task automatic test_mispredict_not_taken;
        push(32'h300, 1'b1, 32'h340);
        resolve(1'b0, 32'h0);
        total_cnt++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h304 || upd_taken !== 1'b0) begin
            $display("[TB] FAIL mispnt_redirect: got valid=%b pc=%h taken=%b expected 1/304/0",
                     redirect_valid, redirect_pc, upd_taken);
        end else pass_cnt++;
        pred_valid  = 1'b1;
        pred_pc     = 32'h3A0;
        pred_taken  = 1'b0;
        res_valid   = 1'b1;
        res_taken   = 1'b0;
        #1;
        total_cnt++;
        if (pred_ready !== 1'b0) begin
            $display("[TB] FAIL mispnt_ready_in_flush: got %b expected 0", pred_ready);
        end else pass_cnt++;
        tick();
        total_cnt++;
        if ({upd_valid, flush} !== 2'b01) begin
            $display("[TB] FAIL mispnt_ignore1: got %b expected 01", {upd_valid, flush});
        end else pass_cnt++;
        tick();
        pred_valid = 1'b0;
        res_valid  = 1'b0;
        total_cnt++;
        if ({upd_valid, flush, pred_ready, underflow_err} !== 4'b0010) begin
            $display("[TB] FAIL mispnt_ignore2: got %b expected 0010",
                     {upd_valid, flush, pred_ready, underflow_err});
        end else pass_cnt++;
        push(32'h310, 1'b0, 32'h0);
        resolve(1'b0, 32'h0);
        total_cnt++;
        if (upd_pc !== 32'h310 || mispredict !== 1'b0) begin
            $display("[TB] FAIL mispnt_push_dropped: got upd_pc=%h mispredict=%b expected 310/0", upd_pc, mispredict);
        end else pass_cnt++;
    endtask

    task automatic test_full_wrap;
        for (int i = 0; i < 4; i++) push(32'h400 + 32'(4 * i), 1'b0, 32'h0);
        total_cnt++;
        if (pred_ready !== 1'b0) begin
            $display("[TB] FAIL full_ready: got %b expected 0", pred_ready);
        end else pass_cnt++;
        res_valid   = 1'b1;
        res_taken   = 1'b0;
        pred_valid  = 1'b1;
        pred_pc     = 32'h410;
        pred_taken  = 1'b0;
        #1;
        total_cnt++;
        if (pred_ready !== 1'b1) begin
            $display("[TB] FAIL full_ready_with_pop: got %b expected 1", pred_ready);
        end else pass_cnt++;
        tick();
        res_valid  = 1'b0;
        pred_valid = 1'b0;
        #1;
        total_cnt++;
        if (upd_pc !== 32'h400 || mispredict !== 1'b0 || pred_ready !== 1'b0) begin
            $display("[TB] FAIL full_pop_push: got upd_pc=%h mispredict=%b ready=%b expected 400/0/0",
                     upd_pc, mispredict, pred_ready);
        end else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            resolve(1'b0, 32'h0);
            total_cnt++;
            if (upd_valid !== 1'b1 || upd_pc !== 32'h404 + 32'(4 * i) || mispredict !== 1'b0) begin
                $display("[TB] FAIL full_order_%0d: got valid=%b pc=%h mispredict=%b expected 1/%h/0",
                         i, upd_valid, upd_pc, mispredict, 32'h404 + 32'(4 * i));
            end else pass_cnt++;
        end
    endtask

    task automatic test_underflow;
        resolve(1'b1, 32'h0);
        total_cnt++;
        if (upd_valid !== 1'b0 || underflow_err !== 1'b1) begin
            $display("[TB] FAIL underflow_set: got upd_valid=%b err=%b expected 0/1", upd_valid, underflow_err);
        end else pass_cnt++;
        tick();
        total_cnt++;
        if (underflow_err !== 1'b1) begin
            $display("[TB] FAIL underflow_sticky: got %b expected 1", underflow_err);
        end else pass_cnt++;
        pred_valid  = 1'b1;
        pred_pc     = 32'h500;
        pred_taken  = 1'b0;
        res_valid   = 1'b1;
        res_taken   = 1'b0;
        tick();
        pred_valid = 1'b0;
        res_valid  = 1'b0;
        total_cnt++;
        if (upd_valid !== 1'b0) begin
            $display("[TB] FAIL underflow_no_bypass: got upd_valid=%b expected 0", upd_valid);
        end else pass_cnt++;
        resolve(1'b0, 32'h0);
        total_cnt++;
        if (upd_valid !== 1'b1 || upd_pc !== 32'h500 || mispredict !== 1'b0) begin
            $display("[TB] FAIL underflow_push_kept: got valid=%b pc=%h mispredict=%b expected 1/500/0",
                     upd_valid, upd_pc, mispredict);
        end else pass_cnt++;
    endtask

    task automatic test_reset_mid_flush;
        push(32'h600, 1'b0, 32'h0);
        resolve(1'b1, 32'h700);
        total_cnt++;
        if (flush !== 1'b1 || redirect_pc !== 32'h700) begin
            $display("[TB] FAIL rstflush_pre: got flush=%b redirect_pc=%h expected 1/700", flush, redirect_pc);
        end else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({redirect_valid, flush, upd_valid, upd_taken, mispredict, underflow_err, pred_ready} !== 7'b0000001) begin
            $display("[TB] FAIL rstflush_flags: got %b expected 0000001",
                     {redirect_valid, flush, upd_valid, upd_taken, mispredict, underflow_err, pred_ready});
        end else pass_cnt++;
        total_cnt++;
        if (upd_pc !== 32'h0 || redirect_pc !== 32'h0) begin
            $display("[TB] FAIL rstflush_pcs: got upd_pc=%h redirect_pc=%h expected 0", upd_pc, redirect_pc);
        end else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        tick();
        push(32'h800, 1'b1, 32'h840);
        resolve(1'b1, 32'h840);
        total_cnt++;
        if (upd_valid !== 1'b1 || upd_pc !== 32'h800 || mispredict !== 1'b0 || flush !== 1'b0) begin
            $display("[TB] FAIL rstflush_recover: got valid=%b pc=%h mispredict=%b flush=%b expected 1/800/0/0",
                     upd_valid, upd_pc, mispredict, flush);
        end else pass_cnt++;
    endtask

`ifdef BRU_PERF_CNT_EN
    task automatic test_perf;
        rst = 1'b1;
        #2;
        @(negedge clk);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            push(32'h900 + 32'(4 * i), 1'b0, 32'h0);
            resolve(1'b0, 32'h0);
        end
        for (int i = 0; i < 2; i++) begin
            push(32'hA00 + 32'(4 * i), 1'b0, 32'h0);
            resolve(1'b1, 32'h980);
            tick();
            tick();
        end
        total_cnt++;
        if (perf_resolved !== 32'd5 || perf_mispredict !== 32'd2) begin
            $display("[TB] FAIL perf_counts: got resolved=%0d mispredict=%0d expected 5/2",
                     perf_resolved, perf_mispredict);
        end else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_correct();
        test_mispredict_taken();
        test_mispredict_not_taken();
        test_full_wrap();
        test_underflow();
        test_reset_mid_flush();
`ifdef BRU_PERF_CNT_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
